// File: rtl/mmio_uart_tx_pkg.sv
// mmio_uart_tx_pkg: register offsets, STATUS bit positions and serializer state encoding
package mmio_uart_tx_pkg;
  localparam logic [1:0] OFF_DATA = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_DIV = 2'd2;
  localparam int ST_BUSY = 0;
  localparam int ST_FULL = 1;
  localparam int ST_EMPTY = 2;
  localparam int ST_OVF = 3;
  localparam int ST_CNT = 8;
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
endpackage

// File: rtl/tx_fifo.sv
// tx_fifo: sync FIFO (i_push/i_pop/i_data in; o_data head, o_full, o_empty, o_count out); a push while full is accepted only alongside a pop
module tx_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 16
) (
  input  logic                     iCLK,
  input  logic                     iRST,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [W-1:0]             i_data,
  output logic [W-1:0]             o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0] r_cnt;
  logic w_push, w_pop;
  assign w_pop = i_pop && !o_empty;
  assign w_push = i_push && (!o_full || w_pop);
  assign o_full = r_cnt == (AW+1)'(DEPTH);
  assign o_empty = r_cnt == '0;
  assign o_count = r_cnt;
  assign o_data = r_mem[r_rp];
  always_ff @(posedge iCLK)
    if (w_push) r_mem[r_wp] <= i_data;
  always_ff @(posedge iCLK or posedge iRST)
    if (iRST) begin
      r_wp <= '0;
      r_rp <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop) r_rp <= r_rp + 1'b1;
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: bus-mapped 8N1 UART transmitter (Dw* load/store responder in, oTX serial line and oBusy out)
module mmio_uart_tx
  import mmio_uart_tx_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'hFF20_0100,
  parameter int FIFO_DEPTH = 16,
  parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        DwReadEnable,
  input  logic        DwWriteEnable,
  input  logic [3:0]  DwByteEnable,
  input  logic [31:0] DwAddress,
  input  logic [31:0] DwWriteData,
  output logic [31:0] DwReadData,
  output logic        oTX,
  output logic        oBusy
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  state_t r_state;
  logic [7:0] r_shift;
  logic [15:0] r_div, r_div_q, r_cyc;
  logic [2:0] r_bit;
  logic r_tx, r_ovf;
  logic w_sel, w_wr, w_push, w_pop, w_full, w_empty, w_bit_end, w_unused;
  logic [1:0] w_off;
  logic [7:0] w_head;
  logic [CW-1:0] w_count;
  logic [31:0] w_cnt_ext, w_status;
  logic [4:0] w_cnt5;
  assign w_sel = DwAddress[31:4] == BASE_ADDR[31:4];
  assign w_off = DwAddress[3:2];
  assign w_wr = DwWriteEnable && w_sel;
  assign w_push = w_wr && w_off == OFF_DATA && DwByteEnable[0];
  assign w_bit_end = r_cyc == r_div_q - 16'd1;
  // A pop starts a frame: from IDLE, or on the last stop-bit cycle for back-to-back frames
  assign w_pop = !w_empty && (r_state == S_IDLE || (r_state == S_STOP && w_bit_end));
  assign oTX = r_tx;
  assign oBusy = r_state != S_IDLE || !w_empty;
  assign w_cnt_ext = 32'(w_count);
  assign w_cnt5 = w_cnt_ext > 32'd31 ? 5'd31 : w_cnt_ext[4:0];
  assign w_status = {19'b0, w_cnt5, 4'b0, r_ovf, w_empty, w_full, oBusy};
  assign DwReadData = (DwReadEnable && w_sel) ?
                      (w_off == OFF_STATUS ? w_status : w_off == OFF_DIV ? {16'b0, r_div} : 32'b0) : 32'b0;
  assign w_unused = &{1'b0, DwAddress[1:0], DwWriteData[31:16], DwByteEnable[3:2]};
  tx_fifo #(.W(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .iCLK(iCLK), .iRST(iRST), .i_push(w_push), .i_pop(w_pop), .i_data(DwWriteData[7:0]),
    .o_data(w_head), .o_full(w_full), .o_empty(w_empty), .o_count(w_count)
  );
  always_ff @(posedge iCLK or posedge iRST)
    if (iRST) begin
      r_ovf <= 1'b0;
      r_div <= DEFAULT_DIV;
    end else begin
      if (w_push && w_full && !w_pop) r_ovf <= 1'b1;
      else if (w_wr && w_off == OFF_STATUS && DwByteEnable[0] && DwWriteData[ST_OVF]) r_ovf <= 1'b0;
      if (w_wr && w_off == OFF_DIV && DwByteEnable[0]) r_div[7:0] <= DwWriteData[7:0];
      if (w_wr && w_off == OFF_DIV && DwByteEnable[1]) r_div[15:8] <= DwWriteData[15:8];
    end
  always_ff @(posedge iCLK or posedge iRST)
    if (iRST) begin
      r_state <= S_IDLE;
      r_shift <= '0;
      r_div_q <= 16'd1;
      r_cyc <= '0;
      r_bit <= '0;
      r_tx <= 1'b1;
    end else if (w_pop) begin
      r_state <= S_START;
      r_shift <= w_head;
      r_div_q <= r_div == '0 ? 16'd1 : r_div;
      r_cyc <= '0;
      r_bit <= '0;
      r_tx <= 1'b0;
    end else begin
      case (r_state)
        S_START:
          if (w_bit_end) begin
            r_state <= S_DATA;
            r_cyc <= '0;
            r_tx <= r_shift[0];
          end else r_cyc <= r_cyc + 16'd1;
        S_DATA:
          if (w_bit_end) begin
            r_cyc <= '0;
            if (r_bit == 3'd7) begin
              r_state <= S_STOP;
              r_tx <= 1'b1;
            end else begin
              r_bit <= r_bit + 3'd1;
              r_shift <= r_shift >> 1;
              r_tx <= r_shift[1];
            end
          end else r_cyc <= r_cyc + 16'd1;
        S_STOP:
          if (w_bit_end) r_state <= S_IDLE;
          else r_cyc <= r_cyc + 16'd1;
        default: ;
      endcase
    end
endmodule
